fft_input_loader: RTL
=====================

Name: fft_input_loader

Overview:
- Upstream of the FFT data-redistribution stage.
- Accepts one complex sample per cycle over a valid/ready stream and assembles 32-sample frames into two ping-pong buffers.
- Presents each completed frame as packed formatWidth*32 real/imag buses, with a valid/ready handshake and a one-cycle start pulse on transfer.
- Latches the per-frame fft_size and forwards it with the frame.

Parameters:
- formatWidth, 9, bit width of one real or imaginary sample.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample.
- s_real  in  formatWidth  sample real part.
- s_imag  in  formatWidth  sample imaginary part.
- s_last  in  1  marks the final sample of a frame.
- fft_size  in  12  size code (32/8/2); sampled on the first beat of each frame.
- frame_valid  out  1  a full frame is presented.
- frame_ready  in  1  downstream accepts the frame.
- frame_real  out  formatWidth*32  packed real samples; sample k at [formatWidth*(k+1)-1 : formatWidth*k].
- frame_imag  out  formatWidth*32  packed imaginary samples; same packing.
- frame_fft_size  out  12  fft_size latched for the presented frame.
- start  out  1  one-cycle pulse, high exactly when frame_valid && frame_ready.
- frame_err  out  1  one-cycle pulse on an s_last/count mismatch.

Behaviour:
- **Storage:** two buffers B0/B1, each 32 x (real, imag) plus a 12-bit size and a state (EMPTY, FULL).
- **Write pointers:** wr_sel (buffer being filled) and wr_cnt (0..31). Read pointer: rd_sel.
- **Reset** (rst=1 at clk edge; also aborts any partial frame):
  - both buffers EMPTY; wr_sel=rd_sel=0; wr_cnt=0.
  - outputs: s_ready=1, frame_valid=0, start=0, frame_err=0, frame_real=0, frame_imag=0, frame_fft_size=0.
- **s_ready** = state[wr_sel]==EMPTY. It depends only on registered state, never combinationally on frame_ready.
- **Accept beat** (s_valid && s_ready):
  - sample is written to slot wr_cnt of buffer wr_sel.
  - if wr_cnt==0, fft_size is latched into that buffer's size.
- **Normal completion:** beat with wr_cnt==31 and s_last=1 → buffer marked FULL, wr_sel toggles, wr_cnt=0, frame_err=0.
- **Missing last:** beat with wr_cnt==31 and s_last=0 → frame still committed exactly as above; frame_err pulses 1 cycle.
- **Early last:** beat with s_last=1 and wr_cnt<31 → partial frame discarded; wr_cnt=0; buffer stays EMPTY; wr_sel unchanged; frame_err pulses 1 cycle.
- **Output side:**
  - frame_valid = state[rd_sel]==FULL.
  - frame_real, frame_imag and frame_fft_size are driven from buffer rd_sel and held stable while frame_valid && !frame_ready.
  - When frame_valid=0 the data buses hold their last value (0 after reset).
- **Transfer** (frame_valid && frame_ready):
  - start=1 in that cycle.
  - on the next edge, buffer rd_sel → EMPTY and rd_sel toggles.
- **Latency:** first frame_valid one cycle after the edge that accepts the 32nd beat.
- **Throughput:** sustains 1 sample/cycle with frame_ready held high; no bubbles.
- **Simultaneous events:** a frame commit on wr_sel and a transfer on rd_sel in the same cycle are both honoured. The freed buffer is visible via s_ready on the following cycle.
- **Both buffers FULL:** s_ready=0; input stalls until a transfer occurs.
- **Data integrity:** a buffer is never written while FULL; no sample is ever dropped or duplicated except by the early-last discard.

Test Plan:
- **Reset values:** apply rst for 2 cycles → s_ready=1, frame_valid=0, start=0, frame_err=0, buses 0.
- **Single frame, formatWidth=9:** stream samples real=k, imag=100+k for k=0..31 with s_last on k=31, fft_size=32, frame_ready=1 → frame_valid and start high one cycle after beat 31. frame_real[8:0]=0, frame_real[287:279]=31, frame_imag[17:9]=101, frame_fft_size=32.
- **Back-pressure:** stream 3 frames back-to-back with frame_ready=0 → s_ready drops after the 64th beat, frame 0 held stable. Raise frame_ready → frames 0, 1, 2 delivered in order, each with one start pulse.
- **Early last:** assert s_last on beat 9 of a frame → frame_err pulse, no frame_valid. The next 32 beats (values 200..231) form a clean frame with slot 0 = 200.
- **Missing last:** 32 beats with no s_last → frame committed and frame_err pulses on the 32nd-beat cycle.
- **Reset mid-fill:** rst after 17 beats while the other buffer is FULL → all state cleared; a subsequent 32-beat frame is delivered correctly with frame_fft_size=8 when fft_size=8 on its first beat.

Source files
------------

// File: rtl/fft_input_loader.sv
// Collects a stream of complex samples into 32-sample frames held in two ping-pong buffers
// and presents each completed frame, with its latched size code, over a valid/ready handshake.
module fft_input_loader #(
    parameter int formatWidth = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [formatWidth-1:0]      s_real,
    input  logic [formatWidth-1:0]      s_imag,
    input  logic                        s_last,
    input  logic [11:0]                 fft_size,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [formatWidth*32-1:0]   frame_real,
    output logic [formatWidth*32-1:0]   frame_imag,
    output logic [11:0]                 frame_fft_size,
    output logic                        start,
    output logic                        frame_err
);

    localparam int FW = formatWidth * 32;

    logic [1:0]             full;
    logic [1:0]             full_next;
    logic                   wr_sel;
    logic                   rd_sel;
    logic [4:0]             wr_cnt;

    logic [formatWidth-1:0] buf_re [2][32];
    logic [formatWidth-1:0] buf_im [2][32];
    logic [11:0]            buf_size [2];

    logic [FW-1:0]          rd_re;
    logic [FW-1:0]          rd_im;
    logic [FW-1:0]          hold_re;
    logic [FW-1:0]          hold_im;
    logic [11:0]            hold_size;

    logic                   accept;
    logic                   at_end;
    logic                   commit;
    logic                   err_next;
    logic                   xfer;

    assign s_ready     = ~full[wr_sel];
    assign frame_valid = full[rd_sel];
    assign accept      = s_valid & s_ready;
    assign at_end      = (wr_cnt == 5'd31);
    assign commit      = accept & at_end;
    // Error whenever s_last disagrees with the slot count: early last or missing last.
    assign err_next    = accept & (at_end ^ s_last);
    assign xfer        = frame_valid & frame_ready;
    assign start       = xfer;

    always_comb begin
        full_next = full;
        if (xfer)
            full_next[rd_sel] = 1'b0;
        if (commit)
            full_next[wr_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 2'b00;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_cnt    <= 5'd0;
            frame_err <= 1'b0;
        end else begin
            full      <= full_next;
            frame_err <= err_next;
            if (accept)
                wr_cnt <= (commit || s_last) ? 5'd0 : wr_cnt + 5'd1;
            if (commit)
                wr_sel <= ~wr_sel;
            if (xfer)
                rd_sel <= ~rd_sel;
        end
    end

    // Sample storage carries no reset; s_ready keeps a FULL buffer from being written.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_re[wr_sel][wr_cnt] <= s_real;
            buf_im[wr_sel][wr_cnt] <= s_imag;
            if (wr_cnt == 5'd0)
                buf_size[wr_sel] <= fft_size;
        end
    end

    always_comb begin
        rd_re = '0;
        rd_im = '0;
        for (int k = 0; k < 32; k++) begin
            rd_re[k*formatWidth +: formatWidth] = buf_re[rd_sel][k];
            rd_im[k*formatWidth +: formatWidth] = buf_im[rd_sel][k];
        end
    end

    // Buses keep showing the last presented frame once the buffer is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_re   <= '0;
            hold_im   <= '0;
            hold_size <= 12'd0;
        end else if (frame_valid) begin
            hold_re   <= rd_re;
            hold_im   <= rd_im;
            hold_size <= buf_size[rd_sel];
        end
    end

    assign frame_real     = frame_valid ? rd_re            : hold_re;
    assign frame_imag     = frame_valid ? rd_im            : hold_im;
    assign frame_fft_size = frame_valid ? buf_size[rd_sel] : hold_size;

endmodule
